// File: rtl/acquire_pkg.sv
// ============================================================================
// acquire_pkg : field widths, a_type codes and beat layout for Acquire traffic
// Rev 1.0
// ============================================================================
`default_nettype none

package acquire_pkg;

  localparam int SRC_W   = 2;
  localparam int DST_W   = 2;
  localparam int BLOCK_W = 26;
  localparam int XID_W   = 1;
  localparam int BEAT_W  = 3;
  localparam int ATYPE_W = 3;
  localparam int UNION_W = 12;
  localparam int DATA_W  = 64;
  localparam int ACQ_W   = 114;

  localparam logic [ATYPE_W-1:0] GET_TYPE        = 3'h0;
  localparam logic [ATYPE_W-1:0] GET_BLOCK_TYPE  = 3'h1;
  localparam logic [ATYPE_W-1:0] PUT_TYPE        = 3'h2;
  localparam logic [ATYPE_W-1:0] PUT_BLOCK_TYPE  = 3'h3;
  localparam logic [ATYPE_W-1:0] PUT_ATOMIC_TYPE = 3'h4;

  typedef struct packed {
    logic [SRC_W-1:0]   header_src;
    logic [DST_W-1:0]   header_dst;
    logic [BLOCK_W-1:0] addr_block;
    logic [XID_W-1:0]   client_xact_id;
    logic [BEAT_W-1:0]  addr_beat;
    logic               is_builtin_type;
    logic [ATYPE_W-1:0] a_type;
    logic [UNION_W-1:0] union_bits;
    logic [DATA_W-1:0]  data;
  } acquire_beat_t;

  // Only a built-in putBlock spans several beats; everything else is one beat.
  function automatic logic is_multi_beat(acquire_beat_t b);
    return b.is_builtin_type && (b.a_type == PUT_BLOCK_TYPE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/acquire_locking_arbiter_rr_pick2.sv
// ============================================================================
// rr_pick2 : 2-way round-robin pick; ptr breaks the tie when both are valid
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = ptr_i;
    if (valid_i == 2'b01) begin
      grant_o = 1'b0;
    end else if (valid_i == 2'b10) begin
      grant_o = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/acquire_locking_arbiter.sv
// ============================================================================
// acquire_locking_arbiter : 2-input Acquire arbiter, locks on putBlock bursts
// Optional io_beat_err burst checker under ACQ_ARB_BEAT_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module acquire_locking_arbiter
  import acquire_pkg::*;
#(
  parameter int N_BEATS   = 8,
  parameter bit RESET_PTR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in0_valid,
  output logic             io_in0_ready,
  input  logic [ACQ_W-1:0] io_in0_bits,
  input  logic             io_in1_valid,
  output logic             io_in1_ready,
  input  logic [ACQ_W-1:0] io_in1_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [ACQ_W-1:0] io_out_bits,
  output logic             io_chosen
`ifdef ACQ_ARB_BEAT_CHECK_EN
  ,
  output logic             io_beat_err
`endif
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

  logic              state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              pick_grant;
  logic              grant;
  logic              fire;
  acquire_beat_t     sel_beat;

  rr_pick2 u_pick (
    .valid_i ({io_in1_valid, io_in0_valid}),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      rr_ptr_q   <= RESET_PTR;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          if (is_multi_beat(sel_beat)) begin
            state_d    = ST_LOCKED;
            owner_d    = grant;
            beat_cnt_d = BEAT_W'(1);
          end else begin
            rr_ptr_d = ~grant;
          end
        end
      end
      ST_LOCKED: begin
        // A stalled owner simply produces no fire, so the count holds.
        if (fire) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = ~grant;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant        = (state_q == ST_LOCKED) ? owner_q : pick_grant;
    io_out_valid = grant ? io_in1_valid : io_in0_valid;
    io_out_bits  = grant ? io_in1_bits : io_in0_bits;
    io_in0_ready = io_out_ready & ~grant;
    io_in1_ready = io_out_ready & grant;
    io_chosen    = grant;
    fire         = io_out_valid & io_out_ready;
  end

  assign sel_beat = io_out_bits;

`ifdef ACQ_ARB_BEAT_CHECK_EN
  logic [BLOCK_W-1:0] first_block_q;
  logic [XID_W-1:0]   first_xid_q;
  logic               beat_err_q;
  logic               beat_bad;

  assign beat_bad = (sel_beat.addr_beat != beat_cnt_q)
                 || (sel_beat.addr_block != first_block_q)
                 || (sel_beat.client_xact_id != first_xid_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_block_q <= '0;
      first_xid_q   <= '0;
      beat_err_q    <= 1'b0;
    end else begin
      if (fire && (state_q == ST_IDLE) && is_multi_beat(sel_beat)) begin
        first_block_q <= sel_beat.addr_block;
        first_xid_q   <= sel_beat.client_xact_id;
      end
      if (fire && (state_q == ST_LOCKED) && beat_bad) begin
        beat_err_q <= 1'b1;
      end
    end
  end

  assign io_beat_err = beat_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_acquire_locking_arbiter.sv
// ============================================================================
// tb_acquire_locking_arbiter : scoreboard bench for acquire_locking_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_acquire_locking_arbiter;
  import acquire_pkg::*;

  localparam int N_BEATS   = 8;
  localparam bit RESET_PTR = 1'b0;

  logic             clk;
  logic             reset;
  logic             io_in0_valid, io_in0_ready;
  logic [ACQ_W-1:0] io_in0_bits;
  logic             io_in1_valid, io_in1_ready;
  logic [ACQ_W-1:0] io_in1_bits;
  logic             io_out_valid, io_out_ready;
  logic [ACQ_W-1:0] io_out_bits;
  logic             io_chosen;
`ifdef ACQ_ARB_BEAT_CHECK_EN
  logic             io_beat_err;
`endif

  acquire_locking_arbiter #(.N_BEATS(N_BEATS), .RESET_PTR(RESET_PTR)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in0_valid (io_in0_valid),
    .io_in0_ready (io_in0_ready),
    .io_in0_bits  (io_in0_bits),
    .io_in1_valid (io_in1_valid),
    .io_in1_ready (io_in1_ready),
    .io_in1_bits  (io_in1_bits),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_chosen    (io_chosen)
`ifdef ACQ_ARB_BEAT_CHECK_EN
    ,
    .io_beat_err  (io_beat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    acquire_beat_t b;
    logic          ch;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   fires    = 0;

  task automatic chk(input string tag, input logic [ACQ_W-1:0] got, input logic [ACQ_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic acquire_beat_t mk(input logic [BLOCK_W-1:0] blk, input logic xid,
                                       input logic [2:0] beat, input logic [2:0] at,
                                       input logic [DATA_W-1:0] data);
    acquire_beat_t b;
    b.header_src      = 2'd1;
    b.header_dst      = 2'd2;
    b.addr_block      = blk;
    b.client_xact_id  = xid;
    b.addr_beat       = beat;
    b.is_builtin_type = 1'b1;
    b.a_type          = at;
    b.union_bits      = 12'h5a5;
    b.data            = data;
    return b;
  endfunction

  function automatic acquire_beat_t get(input logic [DATA_W-1:0] data);
    return mk(26'h0000abc, 1'b0, 3'd0, GET_TYPE, data);
  endfunction

  task automatic push(input acquire_beat_t b, input logic ch);
    exp_t e;
    e.b  = b;
    e.ch = ch;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (io_out_valid && io_out_ready) begin
      fires++;
      if (sb.size() == 0) begin
        chk("unexpected_fire", ACQ_W'(1), ACQ_W'(0));
      end else begin
        e = sb.pop_front();
        chk("fire_bits", io_out_bits, e.b);
        chk("fire_chosen", ACQ_W'(io_chosen), ACQ_W'(e.ch));
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic fin();
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    neg();
    fin();
  endtask

  acquire_beat_t b;
  int            f0;

  initial begin
    reset        = 1'b0;
    io_out_ready = 1'b0;
    io_in0_valid = 1'b1;
    io_in1_valid = 1'b0;
    io_in0_bits  = get(64'h100);
    io_in1_bits  = get(64'h200);
    #3;
    chk("rst_out_valid", ACQ_W'(io_out_valid), ACQ_W'(1));
    chk("rst_chosen", ACQ_W'(io_chosen), ACQ_W'(0));
    chk("rst_state", ACQ_W'(dut.state_q), ACQ_W'(0));
    chk("rst_beat_cnt", ACQ_W'(dut.beat_cnt_q), ACQ_W'(0));
    chk("rst_rr_ptr", ACQ_W'(dut.rr_ptr_q), ACQ_W'(RESET_PTR));
    io_in1_valid = 1'b1;
    #1;
    chk("rst_both_chosen", ACQ_W'(io_chosen), ACQ_W'(RESET_PTR));
    repeat (2) @(posedge clk);
    #1;
    reset        = 1'b1;
    io_out_ready = 1'b1;

    // Alternating single-beat gets
    f0 = fires;
    push(get(64'h100), 1'b0);
    push(get(64'h200), 1'b1);
    push(get(64'h101), 1'b0);
    push(get(64'h201), 1'b1);
    cyc(); io_in0_bits = get(64'h101);
    cyc(); io_in1_bits = get(64'h201);
    cyc();
    cyc();
    io_in0_valid = 1'b0;
    io_in1_valid = 1'b0;
    chk("rr_fires", ACQ_W'(fires - f0), ACQ_W'(4));
    chk("rr_sb_empty", ACQ_W'(sb.size()), ACQ_W'(0));

    // in0 putBlock locks out a continuously valid in1
    io_in1_valid = 1'b1;
    io_in1_bits  = get(64'h210);
    io_in0_valid = 1'b1;
    for (int k = 0; k < N_BEATS; k++) begin
      b = mk(26'h0123456, 1'b1, 3'(k), PUT_BLOCK_TYPE, 64'h300 + 64'(k));
      io_in0_bits = b;
      push(b, 1'b0);
      neg();
      chk("lock_in1_ready", ACQ_W'(io_in1_ready), ACQ_W'(0));
      fin();
    end
    io_in0_bits = get(64'h110);
    push(get(64'h210), 1'b1);
    push(get(64'h110), 1'b0);
    neg();
    chk("after_burst_chosen", ACQ_W'(io_chosen), ACQ_W'(1));
    chk("after_burst_state", ACQ_W'(dut.state_q), ACQ_W'(0));
    chk("after_burst_cnt", ACQ_W'(dut.beat_cnt_q), ACQ_W'(0));
    fin();
    io_in1_valid = 1'b0;
    cyc();
    io_in0_valid = 1'b0;
    chk("lock_sb_empty", ACQ_W'(sb.size()), ACQ_W'(0));

    // Owner stalls mid-burst
    io_in0_valid = 1'b1;
    for (int k = 0; k < N_BEATS; k++) begin
      if (k == 4) begin
        io_in0_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
          neg();
          chk("stall_out_valid", ACQ_W'(io_out_valid), ACQ_W'(0));
          chk("stall_in1_ready", ACQ_W'(io_in1_ready), ACQ_W'(0));
          chk("stall_beat_cnt", ACQ_W'(dut.beat_cnt_q), ACQ_W'(4));
          fin();
        end
        io_in0_valid = 1'b1;
      end
      b = mk(26'h0222222, 1'b0, 3'(k), PUT_BLOCK_TYPE, 64'h400 + 64'(k));
      io_in0_bits = b;
      push(b, 1'b0);
      cyc();
      if (k == 0) begin
        io_in1_valid = 1'b1;
        io_in1_bits  = get(64'h220);
      end
    end
    io_in0_valid = 1'b0;
    push(get(64'h220), 1'b1);
    cyc();
    io_in1_valid = 1'b0;
    chk("stall_sb_empty", ACQ_W'(sb.size()), ACQ_W'(0));

    // Downstream backpressure
    io_out_ready = 1'b0;
    io_in1_valid = 1'b1;
    io_in1_bits  = get(64'h230);
    f0 = fires;
    for (int s = 0; s < 5; s++) begin
      neg();
      chk("bp_out_valid", ACQ_W'(io_out_valid), ACQ_W'(1));
      chk("bp_bits", io_out_bits, get(64'h230));
      chk("bp_rr_ptr", ACQ_W'(dut.rr_ptr_q), ACQ_W'(0));
      fin();
    end
    chk("bp_no_fire", ACQ_W'(fires - f0), ACQ_W'(0));
    io_out_ready = 1'b1;
    push(get(64'h230), 1'b1);
    cyc();
    io_in1_valid = 1'b0;

    // Reset mid-burst from in1
    io_in1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b = mk(26'h0333333, 1'b1, 3'(k), PUT_BLOCK_TYPE, 64'h500 + 64'(k));
      io_in1_bits = b;
      push(b, 1'b1);
      cyc();
    end
    chk("pre_rst_cnt", ACQ_W'(dut.beat_cnt_q), ACQ_W'(5));
    io_in1_bits  = mk(26'h0333333, 1'b1, 3'd5, PUT_BLOCK_TYPE, 64'h505);
    io_out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_state", ACQ_W'(dut.state_q), ACQ_W'(0));
    chk("mid_rst_cnt", ACQ_W'(dut.beat_cnt_q), ACQ_W'(0));
    chk("mid_rst_out_valid", ACQ_W'(io_out_valid), ACQ_W'(1));
    io_in0_valid = 1'b1;
    io_in0_bits  = get(64'h140);
    io_in1_bits  = get(64'h240);
    @(posedge clk);
    #1;
    reset        = 1'b1;
    io_out_ready = 1'b1;
    push(get(64'h140), RESET_PTR);
    neg();
    chk("post_rst_chosen", ACQ_W'(io_chosen), ACQ_W'(RESET_PTR));
    fin();
    io_in0_valid = 1'b0;
    push(get(64'h240), 1'b1);
    cyc();
    io_in1_valid = 1'b0;
    chk("rst_sb_empty", ACQ_W'(sb.size()), ACQ_W'(0));

`ifdef ACQ_ARB_BEAT_CHECK_EN
    // Third beat carries a wrong addr_beat; error is sticky until reset
    chk("err_initial", ACQ_W'(io_beat_err), ACQ_W'(0));
    io_in0_valid = 1'b1;
    for (int k = 0; k < N_BEATS; k++) begin
      b = mk(26'h0444444, 1'b0, (k == 2) ? 3'd5 : 3'(k), PUT_BLOCK_TYPE, 64'h600 + 64'(k));
      io_in0_bits = b;
      push(b, 1'b0);
      neg();
      chk("err_during_burst", ACQ_W'(io_beat_err), ACQ_W'(k >= 3));
      fin();
    end
    io_in0_valid = 1'b0;
    repeat (3) begin
      neg();
      chk("err_sticky", ACQ_W'(io_beat_err), ACQ_W'(1));
      fin();
    end
    reset = 1'b0;
    #1;
    chk("err_cleared", ACQ_W'(io_beat_err), ACQ_W'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
`endif

    cyc();
    chk("final_sb_empty", ACQ_W'(sb.size()), ACQ_W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
